freq_peak_detect: RTL and testbench

- Sits directly downstream of the frequency buffer stage and consumes the same per-bin polar stream (magnitude, phase) as the buffer is filled.
- Scans each frame of TOT_SIZE bins, finds the bin with the largest magnitude, and emits one result per frame (bin index, magnitude, phase, above-threshold flag) on a valid/ready source interface.
- Handles short frames, dropped results and back-pressure explicitly.

---
 rtl/freq_peak_detect.sv | 133 +++++++++++++
 tb/tb_freq_peak_detect.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_peak_detect.sv
// freq_peak_detect: per-frame peak search over a polar bin stream.
// Ports: sink_* polar beats in, source_* one result per frame out, drop_cnt.
//
// Inputs : sink_clk, reset (async, active high), sink_sop, sink_valid,
//          sink_mag, sink_phase, threshold, source_ready.
// Outputs: source_valid, source_bin, source_mag, source_phase,
//          source_found, source_err, drop_cnt (saturating at 255).
module freq_peak_detect #(
    parameter int TOT_SIZE = 1024,
    parameter bit SKIP_DC  = 1'b1
) (
    input  logic                        sink_clk,
    input  logic                        reset,
    input  logic                        sink_sop,
    input  logic                        sink_valid,
    input  logic [31:0]                 sink_mag,
    input  logic [31:0]                 sink_phase,
    input  logic [31:0]                 threshold,
    output logic                        source_valid,
    input  logic                        source_ready,
    output logic [$clog2(TOT_SIZE)-1:0] source_bin,
    output logic [31:0]                 source_mag,
    output logic [31:0]                 source_phase,
    output logic                        source_found,
    output logic                        source_err,
    output logic [7:0]                  drop_cnt
);

    localparam int BW = $clog2(TOT_SIZE);
    localparam logic [BW-1:0] LAST_BIN = BW'(TOT_SIZE - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t          state;
    logic [BW-1:0]   bin_cnt;
    logic [BW-1:0]   best_bin;
    logic [31:0]     best_mag;
    logic [31:0]     best_phase;
    logic [31:0]     thr_q;

    logic [BW-1:0]   next_bin;
    logic            start;
    logic            cont;
    logic            abort;
    logic            take;
    logic            last;
    logic            done;
    logic [BW-1:0]   res_bin;
    logic [31:0]     res_mag;
    logic [31:0]     res_phase;
    logic            res_found;

    always_comb begin
        next_bin  = bin_cnt + BW'(1);
        start     = sink_valid && sink_sop;
        cont      = sink_valid && !sink_sop && (state == SCAN);
        abort     = start && (state == SCAN);
        // With DC skipped, bin 1 is always taken so the stored phase
        // belongs to the stored bin even when bin 1 has zero magnitude.
        take      = cont && ((sink_mag > best_mag) ||
                             (SKIP_DC && (next_bin == BW'(1))));
        last      = cont && (next_bin == LAST_BIN);
        done      = last || abort;
        // On abort take is 0, so the partial frame's best is reported.
        res_bin   = take ? next_bin   : best_bin;
        res_mag   = take ? sink_mag   : best_mag;
        res_phase = take ? sink_phase : best_phase;
        res_found = res_mag > thr_q;
    end

    always_ff @(posedge sink_clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bin_cnt      <= '0;
            best_bin     <= '0;
            best_mag     <= '0;
            best_phase   <= '0;
            thr_q        <= '0;
            source_valid <= 1'b0;
            source_bin   <= '0;
            source_mag   <= '0;
            source_phase <= '0;
            source_found <= 1'b0;
            source_err   <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            if (start) begin
                state   <= SCAN;
                bin_cnt <= '0;
                thr_q   <= threshold;
                if (SKIP_DC) begin
                    best_bin   <= BW'(1);
                    best_mag   <= '0;
                    best_phase <= '0;
                end else begin
                    best_bin   <= '0;
                    best_mag   <= sink_mag;
                    best_phase <= sink_phase;
                end
            end else if (cont) begin
                bin_cnt <= next_bin;
                if (take) begin
                    best_bin   <= next_bin;
                    best_mag   <= sink_mag;
                    best_phase <= sink_phase;
                end
                if (last) begin
                    state <= IDLE;
                end
            end

            // Single-entry output register; a slot frees on handshake.
            if (done) begin
                if (!source_valid || source_ready) begin
                    source_valid <= 1'b1;
                    source_bin   <= res_bin;
                    source_mag   <= res_mag;
                    source_phase <= res_phase;
                    source_found <= res_found;
                    source_err   <= abort;
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (source_valid && source_ready) begin
                source_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_freq_peak_detect.sv
// tb_freq_peak_detect: scoreboard bench for freq_peak_detect.
// Two DUTs (SKIP_DC=1 and SKIP_DC=0) share the sink stream.
module tb_freq_peak_detect;

    localparam int N = 8;

    typedef struct packed {
        logic [2:0]  bin;
        logic [31:0] mag;
        logic [31:0] phase;
        logic        found;
        logic        err;
    } exp_t;

    logic        sink_clk = 1'b0;
    logic        reset = 1'b1;
    logic        sink_sop = 1'b0;
    logic        sink_valid = 1'b0;
    logic [31:0] sink_mag = '0;
    logic [31:0] sink_phase = '0;
    logic [31:0] threshold = '0;
    logic        source_ready = 1'b0;

    logic        v1, v0;
    logic [2:0]  bin1, bin0;
    logic [31:0] mag1, mag0, ph1, ph0;
    logic        found1, found0, err1, err0;
    logic [7:0]  drop1, drop0;

    exp_t q1[$];
    exp_t q0[$];
    int   n_tests = 0;
    int   n_fail = 0;
    logic [31:0] fm[8];
    logic [31:0] fp[8];

    always #5 sink_clk = ~sink_clk;

    freq_peak_detect #(.TOT_SIZE(N), .SKIP_DC(1'b1)) dut (
        .sink_clk(sink_clk), .reset(reset),
        .sink_sop(sink_sop), .sink_valid(sink_valid),
        .sink_mag(sink_mag), .sink_phase(sink_phase),
        .threshold(threshold),
        .source_valid(v1), .source_ready(source_ready),
        .source_bin(bin1), .source_mag(mag1),
        .source_phase(ph1), .source_found(found1),
        .source_err(err1), .drop_cnt(drop1)
    );

    freq_peak_detect #(.TOT_SIZE(N), .SKIP_DC(1'b0)) dut0 (
        .sink_clk(sink_clk), .reset(reset),
        .sink_sop(sink_sop), .sink_valid(sink_valid),
        .sink_mag(sink_mag), .sink_phase(sink_phase),
        .threshold(threshold),
        .source_valid(v0), .source_ready(source_ready),
        .source_bin(bin0), .source_mag(mag0),
        .source_phase(ph0), .source_found(found0),
        .source_err(err0), .drop_cnt(drop0)
    );

    // Reference peak search over the first n bins of a frame.
    function automatic exp_t model(input logic [31:0] m[8],
                                   input logic [31:0] p[8],
                                   input int n, input bit skip,
                                   input logic [31:0] thr, input bit err);
        exp_t e;
        int s;
        s = skip ? 1 : 0;
        e.bin = 3'(s);
        e.mag = '0;
        e.phase = '0;
        if (n > s) begin
            e.mag = m[s];
            e.phase = p[s];
        end
        for (int j = s + 1; j < n; j++) begin
            if (m[j] > e.mag) begin
                e.bin = 3'(j);
                e.mag = m[j];
                e.phase = p[j];
            end
        end
        e.found = e.mag > thr;
        e.err = err;
        return e;
    endfunction

    always @(negedge sink_clk) begin
        exp_t g, e;
        if (!reset && v1 && source_ready) begin
            g = {bin1, mag1, ph1, found1, err1};
            n_tests++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL sb_skip1 unexpected result bin=%0d mag=%0d",
                         bin1, mag1);
            end else begin
                e = q1.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL sb_skip1 got bin=%0d mag=%0d ph=%0d f=%b e=%b want bin=%0d mag=%0d ph=%0d f=%b e=%b",
                             g.bin, g.mag, $signed(g.phase), g.found, g.err,
                             e.bin, e.mag, $signed(e.phase), e.found, e.err);
                end
            end
        end
    end

    always @(negedge sink_clk) begin
        exp_t g, e;
        if (!reset && v0 && source_ready) begin
            g = {bin0, mag0, ph0, found0, err0};
            n_tests++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL sb_skip0 unexpected result bin=%0d mag=%0d",
                         bin0, mag0);
            end else begin
                e = q0.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL sb_skip0 got bin=%0d mag=%0d ph=%0d f=%b e=%b want bin=%0d mag=%0d ph=%0d f=%b e=%b",
                             g.bin, g.mag, $signed(g.phase), g.found, g.err,
                             e.bin, e.mag, $signed(e.phase), e.found, e.err);
                end
            end
        end
    end

    task automatic beat(input bit sop, input logic [31:0] m,
                        input logic [31:0] p, input logic [31:0] thr);
        sink_valid = 1'b1;
        sink_sop = sop;
        sink_mag = m;
        sink_phase = p;
        threshold = thr;
        @(posedge sink_clk);
        #1;
        sink_valid = 1'b0;
        sink_sop = 1'b0;
    endtask

    task automatic beats(input int a, input int b, input logic [31:0] thr);
        for (int j = a; j <= b; j++) begin
            beat(j == 0, fm[j], fp[j], thr);
        end
    endtask

    task automatic push(input int n, input logic [31:0] thr, input bit err);
        q1.push_back(model(fm, fp, n, 1'b1, thr, err));
        q0.push_back(model(fm, fp, n, 1'b0, thr, err));
    endtask

    task automatic idle(input int n);
        sink_valid = 1'b0;
        sink_sop = 1'b0;
        repeat (n) begin
            @(posedge sink_clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        source_ready = 1'b0;
        q1.delete();
        q0.delete();
        idle(2);
        reset = 1'b0;
        idle(1);
    endtask

    task automatic load_base();
        fm = '{5000, 10, 20, 900, 900, 30, 1, 2};
        for (int j = 0; j < N; j++) fp[j] = 32'(j * 10);
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({v1, bin1, mag1, ph1, found1, err1, drop1} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b bin=%0d mag=%0d drop=%0d want all 0",
                     v1, bin1, mag1, drop1);
        end
        load_base();
        push(N, 32'd256, 1'b0);
        beats(0, N - 1, 32'd256);
        n_tests++;
        if (v1 !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_valid got %b want 1", v1);
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({v1, v0, bin1, mag1, ph1, found1, err1, drop1} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got v=%b v0=%b bin=%0d mag=%0d want all 0",
                     v1, v0, bin1, mag1);
        end
        q1.delete();
        q0.delete();
        @(posedge sink_clk);
        #1;
        reset = 1'b0;
        source_ready = 1'b1;
        for (int j = 0; j < 5; j++) beat(1'b0, 32'd9999, 32'd7, 32'd0);
        idle(3);
        n_tests++;
        if (v1 !== 1'b0 || v0 !== 1'b0) begin
            n_fail++;
            $display("FAIL no_sop_ignored got v=%b v0=%b want 0 0", v1, v0);
        end
        beats(0, 4, 32'd0);
        #2;
        reset = 1'b1;
        #4;
        reset = 1'b0;
        idle(12);
        n_tests++;
        if (v1 !== 1'b0 || drop1 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_midframe got v=%b drop=%0d want 0 0",
                     v1, drop1);
        end
    endtask

    task automatic test_single();
        apply_reset();
        source_ready = 1'b1;
        load_base();
        push(N, 32'd256, 1'b0);
        beats(0, N - 2, 32'd256);
        n_tests++;
        if (v1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early_valid got %b want 0", v1);
        end
        beats(N - 1, N - 1, 32'd256);
        n_tests++;
        if (v1 !== 1'b1 || bin1 !== 3'd3 || mag1 !== 32'd900) begin
            n_fail++;
            $display("FAIL single_latency got v=%b bin=%0d mag=%0d want 1 3 900",
                     v1, bin1, mag1);
        end
        idle(3);
    endtask

    task automatic test_threshold();
        apply_reset();
        source_ready = 1'b1;
        load_base();
        push(N, 32'd900, 1'b0);
        beats(0, N - 1, 32'd900);
        idle(3);
        fm = '{1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_0000,
               5, 32'hFFFF_0000, 0, 3};
        for (int j = 0; j < N; j++) fp[j] = 32'(j * 100 - 400);
        push(N, 32'hFFFF_0000, 1'b0);
        beats(0, N - 1, 32'hFFFF_0000);
        idle(3);
    endtask

    task automatic test_short();
        apply_reset();
        source_ready = 1'b1;
        fm = '{100, 50, 700, 3, 700, 9, 0, 0};
        for (int j = 0; j < N; j++) fp[j] = 32'(j * 10 + 1);
        push(6, 32'd256, 1'b1);
        beats(0, 5, 32'd256);
        n_tests++;
        if (v1 !== 1'b0) begin
            n_fail++;
            $display("FAIL short_no_early got %b want 0", v1);
        end
        load_base();
        push(N, 32'd100, 1'b0);
        beats(0, N - 1, 32'd100);
        idle(3);
    endtask

    task automatic test_back_to_back();
        exp_t ea;
        apply_reset();
        source_ready = 1'b0;
        load_base();
        ea = model(fm, fp, N, 1'b1, 32'd256, 1'b0);
        push(N, 32'd256, 1'b0);
        beats(0, N - 1, 32'd256);
        fm = '{7, 8, 9, 10, 11, 6000, 12, 13};
        for (int j = 0; j < N; j++) fp[j] = 32'(-j * 5);
        beats(0, N - 1, 32'd256);
        beats(0, N - 1, 32'd256);
        idle(2);
        n_tests++;
        if (drop1 !== 8'd2 || drop0 !== 8'd2) begin
            n_fail++;
            $display("FAIL bp_drop_cnt got %0d/%0d want 2", drop1, drop0);
        end
        n_tests++;
        if (v1 !== 1'b1 || bin1 !== ea.bin || mag1 !== ea.mag ||
            ph1 !== ea.phase) begin
            n_fail++;
            $display("FAIL bp_hold got v=%b bin=%0d mag=%0d want 1 %0d %0d",
                     v1, bin1, mag1, ea.bin, ea.mag);
        end
        source_ready = 1'b1;
        idle(1);
        n_tests++;
        if (v1 !== 1'b0 || v0 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release got v=%b/%b want 0", v1, v0);
        end
    endtask

    task automatic test_hs_on_complete();
        apply_reset();
        source_ready = 1'b0;
        load_base();
        push(N, 32'd256, 1'b0);
        beats(0, N - 1, 32'd256);
        fm = '{3, 4, 4000, 5, 6, 4000, 2, 1};
        for (int j = 0; j < N; j++) fp[j] = 32'(j * 3);
        push(N, 32'd5000, 1'b0);
        beats(0, N - 2, 32'd5000);
        source_ready = 1'b1;
        beats(N - 1, N - 1, 32'd5000);
        source_ready = 1'b0;
        n_tests++;
        if (v1 !== 1'b1 || drop1 !== 8'd0 || bin1 !== 3'd2) begin
            n_fail++;
            $display("FAIL hs_complete got v=%b drop=%0d bin=%0d want 1 0 2",
                     v1, drop1, bin1);
        end
        idle(2);
        source_ready = 1'b1;
        idle(3);
    endtask

    initial begin
        test_reset();
        test_single();
        test_threshold();
        test_short();
        test_back_to_back();
        test_hs_on_complete();
        idle(4);
        n_tests++;
        if (q1.size() != 0 || q0.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d/%0d pending want 0",
                     q1.size(), q0.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
